// File: rtl/time_keeper_pkg.sv
// Shared types, field limits and the wrap-around step used when editing a field.
package time_keeper_pkg;

  typedef enum logic [1:0] {
    SEL_HOURS = 2'b00,
    SEL_MIN   = 2'b01,
    SEL_SEC   = 2'b10,
    SEL_NONE  = 2'b11
  } field_sel_t;

  localparam int HOURS_W = 5;
  localparam int MS_W    = 6;

  localparam logic [MS_W-1:0] HOURS_MAX = 6'd23;
  localparam logic [MS_W-1:0] MIN_MAX   = 6'd59;
  localparam logic [MS_W-1:0] SEC_MAX   = 6'd59;

  // Increment or decrement one field modulo (max+1), with no carry out.
  function automatic logic [MS_W-1:0] step_field(input logic [MS_W-1:0] value,
                                                  input logic [MS_W-1:0] max,
                                                  input logic            up);
    if (up) return (value == max) ? '0 : value + 1'b1;
    else    return (value == '0) ? max : value - 1'b1;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Synchronizes and debounces one active-low key, emitting a one-cycle press pulse.
// With TIME_KEEPER_AUTO_REPEAT_EN defined, a held key also auto-repeats while repeat_en is high.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 500_000
`ifdef TIME_KEEPER_AUTO_REPEAT_EN
  ,
  parameter int REPEAT_CYCLES   = 12_500_000
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
`ifdef TIME_KEEPER_AUTO_REPEAT_EN
  input  logic repeat_en,
`endif
  output logic level,
  output logic press
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      sync_reg;
  logic [DB_W-1:0] db_cnt_reg;
  logic            level_reg;
  logic            press_reg;
  logic            pressed_sync;
  logic            flip;

  assign pressed_sync = ~sync_reg[1];
  assign flip         = (pressed_sync != level_reg) && (db_cnt_reg == DB_LAST);

  // Synchronizer resets to the released level so reset never looks like a press.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_reg   <= 2'b11;
      db_cnt_reg <= '0;
      level_reg  <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[0], key_n};
      if (pressed_sync == level_reg) begin
        db_cnt_reg <= '0;
      end else if (flip) begin
        db_cnt_reg <= '0;
        level_reg  <= ~level_reg;
      end else begin
        db_cnt_reg <= db_cnt_reg + DB_W'(1);
      end
    end
  end

`ifdef TIME_KEEPER_AUTO_REPEAT_EN
  localparam int RP_W = $clog2(2 * REPEAT_CYCLES + 1);
  localparam logic [RP_W-1:0] RP_FIRST = RP_W'(2 * REPEAT_CYCLES - 1);
  localparam logic [RP_W-1:0] RP_NEXT  = RP_W'(REPEAT_CYCLES - 1);

  logic [RP_W-1:0] rp_cnt_reg;
  logic            rp_phase_reg;
  logic            held;
  logic            rp_fire;

  // Repeating stops as soon as the synchronized key shows release.
  assign held    = repeat_en & level_reg & pressed_sync;
  assign rp_fire = held && (rp_cnt_reg == (rp_phase_reg ? RP_NEXT : RP_FIRST));

  always_ff @(posedge clk) begin
    if (reset) begin
      press_reg    <= 1'b0;
      rp_cnt_reg   <= '0;
      rp_phase_reg <= 1'b0;
    end else begin
      press_reg <= (flip & ~level_reg) | rp_fire;
      if (!held) begin
        rp_cnt_reg   <= '0;
        rp_phase_reg <= 1'b0;
      end else if (rp_fire) begin
        rp_cnt_reg   <= '0;
        rp_phase_reg <= 1'b1;
      end else begin
        rp_cnt_reg <= rp_cnt_reg + RP_W'(1);
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) press_reg <= 1'b0;
    else       press_reg <= flip & ~level_reg;
  end
`endif

  assign level = level_reg;
  assign press = press_reg;

endmodule

// File: rtl/time_keeper.sv
// Time-of-day counter with 1 Hz prescaler and key-driven field editing in set mode.
// Optional auto-repeat of held keys is enabled by defining TIME_KEEPER_AUTO_REPEAT_EN.
module time_keeper
  import time_keeper_pkg::*;
#(
  parameter int CLK_HZ          = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int REPEAT_CYCLES   = 12_500_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               on,
  input  logic               set,
  input  logic [1:0]         sethms,
  input  logic [1:0]         upDown,
  output logic [HOURS_W-1:0] hours,
  output logic [MS_W-1:0]    min,
  output logic [MS_W-1:0]    sec,
  output logic               tick
);

  localparam int PS_W = $clog2(CLK_HZ + 1);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLK_HZ - 1);

  logic               run;
  logic               edit;
  logic [1:0]         key_press;
  field_sel_t         sel;

  logic [PS_W-1:0]    presc_reg, presc_next;
  logic [HOURS_W-1:0] hours_reg, hours_next;
  logic [MS_W-1:0]    min_reg, min_next;
  logic [MS_W-1:0]    sec_reg, sec_next;
  logic               tick_reg, tick_next;

  assign run  = on & ~set;
  assign edit = on & set;
  assign sel  = field_sel_t'(sethms);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_key
`ifdef TIME_KEEPER_AUTO_REPEAT_EN
      button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_CYCLES  (REPEAT_CYCLES)
      ) u_debounce (
        .clk      (clk),
        .reset    (reset),
        .key_n    (upDown[gi]),
        .repeat_en(edit),
        .level    (),
        .press    (key_press[gi])
      );
`else
      button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk  (clk),
        .reset(reset),
        .key_n(upDown[gi]),
        .level(),
        .press(key_press[gi])
      );
`endif
    end
`ifndef TIME_KEEPER_AUTO_REPEAT_EN
    // REPEAT_CYCLES only matters to the auto-repeat build.
    if (REPEAT_CYCLES < 1) begin : g_repeat_cycles_unused
    end
`endif
  endgenerate

  always_comb begin
    presc_next = presc_reg;
    hours_next = hours_reg;
    min_next   = min_reg;
    sec_next   = sec_reg;
    tick_next  = 1'b0;
    if (run) begin
      if (presc_reg == PS_LAST) begin
        presc_next = '0;
        tick_next  = 1'b1;
        if (sec_reg == SEC_MAX) begin
          sec_next = '0;
          if (min_reg == MIN_MAX) begin
            min_next   = '0;
            hours_next = (hours_reg == HOURS_W'(HOURS_MAX)) ? '0 : hours_reg + 1'b1;
          end else begin
            min_next = min_reg + 1'b1;
          end
        end else begin
          sec_next = sec_reg + 1'b1;
        end
      end else begin
        presc_next = presc_reg + PS_W'(1);
      end
    end else begin
      // Prescaler held at zero so the first second after resuming is a full one.
      presc_next = '0;
      if (edit && (key_press[0] ^ key_press[1])) begin
        case (sel)
          SEL_HOURS: hours_next = HOURS_W'(step_field({1'b0, hours_reg}, HOURS_MAX, key_press[0]));
          SEL_MIN:   min_next   = step_field(min_reg, MIN_MAX, key_press[0]);
          SEL_SEC:   sec_next   = step_field(sec_reg, SEC_MAX, key_press[0]);
          default:   ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_reg <= '0;
      hours_reg <= '0;
      min_reg   <= '0;
      sec_reg   <= '0;
      tick_reg  <= 1'b0;
    end else begin
      presc_reg <= presc_next;
      hours_reg <= hours_next;
      min_reg   <= min_next;
      sec_reg   <= sec_next;
      tick_reg  <= tick_next;
    end
  end

  assign hours = hours_reg;
  assign min   = min_reg;
  assign sec   = sec_reg;
  assign tick  = tick_reg;

endmodule

// File: tb/tb_time_keeper.sv
// Scoreboard bench for time_keeper: expected times are queued as stimulus is driven and checked later.
module tb_time_keeper;

  localparam int CLK_HZ = 10;
  localparam int DB     = 4;
  localparam int RPT    = 8;

  logic       clk = 1'b0;
  logic       reset, on, set;
  logic [1:0] sethms, upDown;
  logic [4:0] hours;
  logic [5:0] min, sec;
  logic       tick;

  time_keeper #(
    .CLK_HZ         (CLK_HZ),
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_CYCLES  (RPT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .on    (on),
    .set   (set),
    .sethms(sethms),
    .upDown(upDown),
    .hours (hours),
    .min   (min),
    .sec   (sec),
    .tick  (tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] h;
    logic [5:0] m;
    logic [5:0] s;
  } hms_t;

  hms_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_h, m_m, m_s;

  function automatic hms_t model_hms();
    hms_t v;
    v.h = 5'(m_h);
    v.m = 6'(m_m);
    v.s = 6'(m_s);
    return v;
  endfunction

  function automatic string fmt(input hms_t v);
    return $sformatf("%0d:%0d:%0d", v.h, v.m, v.s);
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_tick();
    m_s = m_s + 1;
    if (m_s == 60) begin
      m_s = 0;
      m_m = m_m + 1;
      if (m_m == 60) begin
        m_m = 0;
        m_h = (m_h + 1) % 24;
      end
    end
  endtask

  task automatic model_adjust(input bit up);
    if (on && set) begin
      case (sethms)
        2'b00: m_h = up ? (m_h + 1) % 24 : (m_h + 23) % 24;
        2'b01: m_m = up ? (m_m + 1) % 60 : (m_m + 59) % 60;
        2'b10: m_s = up ? (m_s + 1) % 60 : (m_s + 59) % 60;
        default: ;
      endcase
    end
  endtask

  // k: 0 = up, 1 = down, 2 = both together
  task automatic press_key(input int k, input int hold);
    upDown = (k == 0) ? 2'b10 : (k == 1) ? 2'b01 : 2'b00;
    step(hold);
    upDown = 2'b11;
    step(8);
    if (k < 2) model_adjust(k == 0);
    $display("press key=%0d sel=%0d on=%0b set=%0b -> %0d:%0d:%0d", k, sethms, on, set, m_h, m_m, m_s);
  endtask

  task automatic do_reset(input bit set_mode);
    reset  = 1'b1;
    on     = 1'b1;
    set    = set_mode;
    sethms = 2'b11;
    upDown = 2'b11;
    step(3);
    reset = 1'b0;
    m_h = 0; m_m = 0; m_s = 0;
  endtask

  task automatic test_reset();
    hms_t got, e;
    reset = 1'b1; on = 1'b1; set = 1'b0; sethms = 2'b11; upDown = 2'b11;
    step(3);
    m_h = 0; m_m = 0; m_s = 0;
    exp_q.push_back(model_hms());
    got = {hours, min, sec};
    e = exp_q.pop_front();
    n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL reset_time: got %s required %s", fmt(got), fmt(e)); end
    n_cmp++;
    if (tick !== 1'b0) begin n_bad++; $display("FAIL reset_tick: got %b required 0", tick); end
    reset = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step(1);
      n_cmp++;
      if (tick !== (k % 10 == 0)) begin
        n_bad++; $display("FAIL run_tick cycle %0d: got %b required %b", k, tick, (k % 10 == 0));
      end
      if (k % 10 == 0) model_tick();
    end
    exp_q.push_back(model_hms());
    got = {hours, min, sec};
    e = exp_q.pop_front();
    n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL run_20_cycles: got %s required %s", fmt(got), fmt(e)); end
    $display("test_reset done at %0d:%0d:%0d", hours, min, sec);
  endtask

  task automatic test_rollover();
    hms_t got, e;
    do_reset(1'b1);
    sethms = 2'b00; press_key(1, 8);
    sethms = 2'b01; press_key(1, 8);
    sethms = 2'b10; press_key(1, 8); press_key(1, 8);
    exp_q.push_back(model_hms());
    got = {hours, min, sec};
    e = exp_q.pop_front();
    n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL preload_235958: got %s required %s", fmt(got), fmt(e)); end
    set = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step(1);
      if (k % 10 == 0) begin
        model_tick();
        exp_q.push_back(model_hms());
        got = {hours, min, sec};
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== e || tick !== 1'b1) begin
          n_bad++; $display("FAIL rollover cycle %0d: got %s tick %b required %s tick 1", k, fmt(got), tick, fmt(e));
        end
      end
    end
  endtask

  task automatic test_set_keys();
    hms_t got, e;
    do_reset(1'b1);
    sethms = 2'b00; press_key(1, 10);
    sethms = 2'b01; press_key(1, 10);
    for (int i = 0; i < 2; i++) begin
      press_key(i == 0 ? 0 : 1, 10);
      exp_q.push_back(model_hms());
      got = {hours, min, sec};
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin n_bad++; $display("FAIL set_min_wrap %0d: got %s required %s", i, fmt(got), fmt(e)); end
    end
    sethms = 2'b10; press_key(1, 10); press_key(0, 10);
    exp_q.push_back(model_hms());
    got = {hours, min, sec};
    e = exp_q.pop_front();
    n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL set_sec_wrap: got %s required %s", fmt(got), fmt(e)); end
    sethms = 2'b00; press_key(0, 10);
    exp_q.push_back(model_hms());
    got = {hours, min, sec};
    e = exp_q.pop_front();
    n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL set_hours_wrap: got %s required %s", fmt(got), fmt(e)); end
  endtask

  task automatic test_bounce();
    hms_t got, e;
    sethms = 2'b10;
    for (int i = 0; i < 6; i++) begin
      upDown = (i % 2 == 0) ? 2'b10 : 2'b11;
      step(2);
    end
    exp_q.push_back(model_hms());
    got = {hours, min, sec};
    e = exp_q.pop_front();
    n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL bounce_no_pulse: got %s required %s", fmt(got), fmt(e)); end
    upDown = 2'b10;
    step(6);
    exp_q.push_back(model_hms());
    got = {hours, min, sec};
    e = exp_q.pop_front();
    n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL bounce_early: got %s required %s", fmt(got), fmt(e)); end
    step(1);
    model_adjust(1'b1);
    exp_q.push_back(model_hms());
    got = {hours, min, sec};
    e = exp_q.pop_front();
    n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL bounce_stable_pulse: got %s required %s", fmt(got), fmt(e)); end
    upDown = 2'b11;
    step(8);
    $display("bounce sequence done -> %0d:%0d:%0d", m_h, m_m, m_s);
  endtask

  task automatic test_simultaneous();
    hms_t got, e;
    sethms = 2'b10;
    for (int i = 0; i < 60 && m_s != 30; i++) press_key(0, 8);
    press_key(2, 8);
    exp_q.push_back(model_hms());
    got = {hours, min, sec};
    e = exp_q.pop_front();
    n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL both_keys: got %s required %s", fmt(got), fmt(e)); end
    sethms = 2'b11;
    press_key(0, 8);
    exp_q.push_back(model_hms());
    got = {hours, min, sec};
    e = exp_q.pop_front();
    n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL sel_none: got %s required %s", fmt(got), fmt(e)); end
  endtask

  task automatic test_freeze();
    hms_t got, e;
    int   tick_seen;
    do_reset(1'b1);
    sethms = 2'b00;
    for (int i = 0; i < 24 && m_h != 12; i++) press_key(0, 8);
    sethms = 2'b01;
    for (int i = 0; i < 60 && m_m != 34; i++) press_key(1, 8);
    sethms = 2'b10;
    for (int i = 0; i < 60 && m_s != 56; i++) press_key(1, 8);
    exp_q.push_back(model_hms());
    on = 1'b0;
    set = 1'b0;
    tick_seen = 0;
    for (int k = 0; k < 14; k++) begin
      step(1);
      if (tick !== 1'b0) tick_seen++;
    end
    press_key(0, 8);
    tick_seen += (tick !== 1'b0) ? 1 : 0;
    got = {hours, min, sec};
    e = exp_q.pop_front();
    n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL freeze_values: got %s required %s", fmt(got), fmt(e)); end
    n_cmp++;
    if (tick_seen != 0) begin n_bad++; $display("FAIL freeze_tick: got %0d ticks required 0", tick_seen); end
    on = 1'b1;
    step(9);
    n_cmp++;
    if (tick !== 1'b0) begin n_bad++; $display("FAIL resume_early_tick: got %b required 0", tick); end
    step(1);
    model_tick();
    exp_q.push_back(model_hms());
    got = {hours, min, sec};
    e = exp_q.pop_front();
    n_cmp++;
    if (got !== e || tick !== 1'b1) begin
      n_bad++; $display("FAIL resume_tick: got %s tick %b required %s tick 1", fmt(got), tick, fmt(e));
    end
  endtask

`ifdef TIME_KEEPER_AUTO_REPEAT_EN
  task automatic test_auto_repeat();
    hms_t got, e;
    do_reset(1'b1);
    sethms = 2'b10;
    upDown = 2'b10;
    step(40);
    upDown = 2'b11;
    step(10);
    for (int i = 0; i < 4; i++) model_adjust(1'b1);
    exp_q.push_back(model_hms());
    got = {hours, min, sec};
    e = exp_q.pop_front();
    n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL auto_repeat: got %s required %s", fmt(got), fmt(e)); end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; on = 1'b0; set = 1'b0; sethms = 2'b11; upDown = 2'b11;
    step(1);
    test_reset();
    test_rollover();
    test_set_keys();
    test_bounce();
    test_simultaneous();
    test_freeze();
`ifdef TIME_KEEPER_AUTO_REPEAT_EN
    test_auto_repeat();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
